// File: rtl/sb_sram_slave.sv
// System-bus slave that serves one request at a time from a single-port synchronous SRAM.
// The read data and the write response are held until the master takes them.
module sb_sram_slave #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sb_arvalid,
   output logic              sb_arready,
   input  logic [31:0]       sb_araddr,
   output logic              sb_rvalid,
   input  logic              sb_rready,
   output logic [31:0]       sb_rdata,
   input  logic              sb_wvalid,
   output logic              sb_wready,
   input  logic [31:0]       sb_waddr,
   input  logic [31:0]       sb_wdata,
   input  logic [3:0]        sb_wstrb,
   output logic              sb_bvalid,
   input  logic              sb_bready,
   output logic              sb_bresp,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_RESP} state_t;

   state_t state, state_nxt;
   logic   wr_acc, rd_acc, wr_err, rd_err;

   // Bits 31:30 are decoded by the fabric; anything set between them and the word index is out of range.
   function automatic logic addr_err(input logic [31:0] addr);
      logic [29:0] hi;
      hi = addr[29:0] >> (ADDR_W + 2);
      return |hi;
   endfunction

   assign sb_wready  = (state == IDLE);
   assign sb_arready = (state == IDLE) & ~sb_wvalid;
   assign sb_rvalid  = (state == RD_RESP);
   assign sb_bvalid  = (state == WR_RESP);

   assign wr_acc = sb_wvalid & sb_wready;
   assign rd_acc = sb_arvalid & sb_arready;
   assign wr_err = addr_err(sb_waddr);
   assign rd_err = addr_err(sb_araddr);

   assign ram_addr  = sb_wvalid ? sb_waddr[ADDR_W+1:2] : sb_araddr[ADDR_W+1:2];
   assign ram_wdata = sb_wdata;

   always_comb begin
      state_nxt = state;
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      case (state)
         IDLE: begin
            if (wr_acc) begin
               state_nxt = WR_RESP;
               if (!wr_err && !rst) begin
                  ram_en = 1'b1;
                  ram_we = sb_wstrb;
               end
            end else if (rd_acc) begin
               state_nxt = rd_err ? RD_RESP : RD_WAIT;
               if (!rd_err && !rst) ram_en = 1'b1;
            end
         end
         RD_WAIT: state_nxt = RD_RESP;
         RD_RESP: if (sb_rready) state_nxt = IDLE;
         WR_RESP: if (sb_bready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Response registers stay frozen while the master stalls in RD_RESP / WR_RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sb_rdata <= 32'h0;
         sb_bresp <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && wr_acc) sb_bresp <= wr_err;
         if (state == IDLE && !wr_acc && rd_acc && rd_err) sb_rdata <= 32'h0;
         if (state == RD_WAIT) sb_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_sb_sram_slave.sv
// Self-checking bench for sb_sram_slave: directed vector table, corner-case sequences,
// and random traffic scored against a word-array reference memory.
module tb_sb_sram_slave;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          sb_arvalid, sb_arready, sb_rvalid, sb_rready;
   logic [31:0]   sb_araddr, sb_rdata;
   logic          sb_wvalid, sb_wready, sb_bvalid, sb_bready, sb_bresp;
   logic [31:0]   sb_waddr, sb_wdata;
   logic [3:0]    sb_wstrb;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   int checks = 0;
   int errors = 0;
   int en_count = 0;
   int en_in_rst = 0;

   logic [31:0] sram    [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   sb_sram_slave #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .sb_arvalid(sb_arvalid), .sb_arready(sb_arready), .sb_araddr(sb_araddr),
      .sb_rvalid(sb_rvalid), .sb_rready(sb_rready), .sb_rdata(sb_rdata),
      .sb_wvalid(sb_wvalid), .sb_wready(sb_wready), .sb_waddr(sb_waddr),
      .sb_wdata(sb_wdata), .sb_wstrb(sb_wstrb),
      .sb_bvalid(sb_bvalid), .sb_bready(sb_bready), .sb_bresp(sb_bresp),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Single-port synchronous SRAM with byte enables
   always @(posedge clk) begin
      if (ram_en) begin
         en_count <= en_count + 1;
         if (ram_we == 4'b0000) ram_rdata <= sram[ram_addr];
         else
            for (int i = 0; i < 4; i++)
               if (ram_we[i]) sram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
      if (rst && (ram_en || ram_we != 4'b0000)) en_in_rst <= en_in_rst + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain address arithmetic over a word array
   function automatic bit ref_bad(input logic [31:0] a);
      return ((a & 32'h3FFF_FFFF) >> (AW + 2)) != 0;
   endfunction

   function automatic int ref_idx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int k;
      logic [31:0] w;
      if (ref_bad(a)) return;
      k = ref_idx(a);
      w = ref_mem[k];
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[k] = w;
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_bad(a)) return 32'h0;
      return ref_mem[ref_idx(a)];
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic resp);
      int n;
      int en0;
      logic hs, r0;
      sb_waddr = a; sb_wdata = d; sb_wstrb = s; sb_wvalid = 1'b1;
      n = 0; hs = 1'b0; en0 = en_count;
      while (!hs && n < 50) begin
         @(negedge clk); hs = sb_wready;
         @(posedge clk); #1; n++;
      end
      sb_wvalid = 1'b0;
      check("wr_accept", {31'h0, hs}, 32'h1);
      check("wr_bvalid_lat", {31'h0, sb_bvalid}, 32'h1);
      check("wr_ram_access", en_count - en0, ref_bad(a) ? 0 : 1);
      r0 = sb_bresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("wr_hold_bvalid", {31'h0, sb_bvalid}, 32'h1);
         check("wr_hold_bresp", {31'h0, sb_bresp}, {31'h0, r0});
         check("wr_hold_wready", {31'h0, sb_wready}, 32'h0);
         @(posedge clk); #1;
      end
      sb_bready = 1'b1;
      @(negedge clk); resp = sb_bresp;
      @(posedge clk); #1;
      sb_bready = 1'b0;
      check("wr_b2b_wready", {31'h0, sb_wready}, 32'h1);
   endtask

   task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d);
      int n, lat, en0;
      logic hs;
      logic [31:0] d0;
      sb_araddr = a; sb_arvalid = 1'b1;
      n = 0; hs = 1'b0; en0 = en_count;
      while (!hs && n < 50) begin
         @(negedge clk); hs = sb_arready;
         @(posedge clk); #1; n++;
      end
      sb_arvalid = 1'b0;
      check("rd_accept", {31'h0, hs}, 32'h1);
      lat = 0;
      while (!sb_rvalid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      // Handshake cycle + 1 (good address: SRAM access cycle) before rvalid
      check("rd_latency", lat, ref_bad(a) ? 0 : 1);
      check("rd_ram_access", en_count - en0, ref_bad(a) ? 0 : 1);
      d0 = sb_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rd_hold_rvalid", {31'h0, sb_rvalid}, 32'h1);
         check("rd_hold_rdata", sb_rdata, d0);
         check("rd_hold_arready", {31'h0, sb_arready}, 32'h0);
         @(posedge clk); #1;
      end
      sb_rready = 1'b1;
      @(negedge clk); d = sb_rdata;
      @(posedge clk); #1;
      sb_rready = 1'b0;
      check("rd_b2b_arready", {31'h0, sb_arready}, 32'h1);
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_bresp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic        resp;
      logic [31:0] d, a, wd, b_addr, a_addr;
      logic [3:0]  s;
      int          bad_words, n;
      logic        hs;

      vecs[0]  = '{1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h4000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0};
      vecs[2]  = '{1'b1, 32'h4000_0010, 32'h00AB_0000, 4'b0100, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 32'h4000_0010, 32'h0, 4'h0, 32'h12AB_5678, 1'b0};
      vecs[4]  = '{1'b1, 32'h4000_4000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1};
      vecs[5]  = '{1'b0, 32'h4000_4000, 32'h0, 4'h0, 32'h0, 1'b0};
      vecs[6]  = '{1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_3FFC, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0};
      vecs[9]  = '{1'b1, 32'h4000_0013, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
      vecs[10] = '{1'b0, 32'h4000_0011, 32'h0, 4'h0, 32'h12AB_5678, 1'b0};
      vecs[11] = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h12AB_5678, 1'b0};
      vecs[12] = '{1'b0, 32'h2000_0000, 32'h0, 4'h0, 32'h0, 1'b0};

      for (int i = 0; i < DEPTH; i++) begin
         sram[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      ram_rdata = 32'h0;
      rst = 1'b1;
      sb_arvalid = 1'b0; sb_araddr = 32'h0; sb_rready = 1'b0;
      sb_wvalid = 1'b0; sb_waddr = 32'h0; sb_wdata = 32'h0; sb_wstrb = 4'h0;
      sb_bready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rvalid", {31'h0, sb_rvalid}, 32'h0);
      check("rst_bvalid", {31'h0, sb_bvalid}, 32'h0);
      check("rst_rdata", sb_rdata, 32'h0);
      check("rst_bresp", {31'h0, sb_bresp}, 32'h0);
      check("rst_ram_en", {31'h0, ram_en}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_wready", {31'h0, sb_wready}, 32'h1);
      check("idle_arready", {31'h0, sb_arready}, 32'h1);
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp);
            check($sformatf("vec%0d_bresp", i), {31'h0, resp}, {31'h0, vecs[i].exp_bresp});
            ref_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         end else begin
            do_read(vecs[i].addr, i % 3, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
         end
      end

      // Stalled read response stays put for 5 cycles
      do_write(32'h4000_0014, 32'hCAFE_F00D, 4'hF, 0, resp);
      ref_write(32'h4000_0014, 32'hCAFE_F00D, 4'hF);
      do_read(32'h4000_0014, 5, d);
      check("stall_rdata", d, 32'hCAFE_F00D);

      // Same-cycle read and write: write first, read right after the write response
      a_addr = 32'h4000_0014; b_addr = 32'h4000_0020;
      sb_araddr = a_addr; sb_arvalid = 1'b1;
      sb_waddr = b_addr; sb_wdata = 32'h0BAD_CAFE; sb_wstrb = 4'hF; sb_wvalid = 1'b1;
      @(negedge clk);
      check("coll_wready", {31'h0, sb_wready}, 32'h1);
      check("coll_arready", {31'h0, sb_arready}, 32'h0);
      @(posedge clk); #1;
      sb_wvalid = 1'b0;
      ref_write(b_addr, 32'h0BAD_CAFE, 4'hF);
      check("coll_bvalid", {31'h0, sb_bvalid}, 32'h1);
      @(negedge clk);
      check("coll_arready_wresp", {31'h0, sb_arready}, 32'h0);
      @(posedge clk); #1;
      sb_bready = 1'b1;
      @(posedge clk); #1;
      sb_bready = 1'b0;
      @(negedge clk);
      check("coll_arready_after", {31'h0, sb_arready}, 32'h1);
      @(posedge clk); #1;
      sb_arvalid = 1'b0;
      n = 0;
      while (!sb_rvalid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check("coll_rd_lat", n, 1);
      check("coll_rdata", sb_rdata, ref_read(a_addr));
      sb_rready = 1'b1;
      @(posedge clk); #1;
      sb_rready = 1'b0;

      // Reset while holding a write response
      sb_waddr = 32'h4000_0030; sb_wdata = 32'h5555_AAAA; sb_wstrb = 4'hF; sb_wvalid = 1'b1;
      @(posedge clk); #1;
      sb_wvalid = 1'b0;
      ref_write(32'h4000_0030, 32'h5555_AAAA, 4'hF);
      @(negedge clk);
      check("rstw_bvalid_before", {31'h0, sb_bvalid}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstw_bvalid", {31'h0, sb_bvalid}, 32'h0);
      check("rstw_wready", {31'h0, sb_wready}, 32'h1);

      // Reset while holding read data
      sb_araddr = 32'h4000_0030; sb_arvalid = 1'b1;
      @(posedge clk); #1;
      sb_arvalid = 1'b0;
      @(posedge clk); #1;
      check("rstr_rvalid_before", {31'h0, sb_rvalid}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstr_rvalid", {31'h0, sb_rvalid}, 32'h0);
      check("rstr_rdata", sb_rdata, 32'h0);
      check("rstr_arready", {31'h0, sb_arready}, 32'h1);

      // Write presented during reset must not touch the SRAM
      sb_waddr = 32'h4000_0030; sb_wdata = 32'hFFFF_0000; sb_wstrb = 4'hF; sb_wvalid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_wr_ram_en", {31'h0, ram_en}, 32'h0);
      check("rst_wr_ram_we", {28'h0, ram_we}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; sb_wvalid = 1'b0;
      check("rst_wr_bvalid", {31'h0, sb_bvalid}, 32'h0);
      do_read(32'h4000_0030, 0, d);
      check("rst_wr_data", d, 32'h5555_AAAA);

      // Random traffic against the reference memory
      for (int t = 0; t < 200; t++) begin
         a = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(14, 29));
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, wd, s, $urandom_range(0, 3), resp);
            check("rnd_bresp", {31'h0, resp}, {31'h0, ref_bad(a)});
            ref_write(a, wd, s);
         end else begin
            do_read(a, $urandom_range(0, 3), d);
            check("rnd_rdata", d, ref_read(a));
         end
      end

      bad_words = 0;
      for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad_words++;
      check("sram_contents", bad_words, 0);
      check("ram_en_in_reset", en_in_rst, 0);

      hs = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
